// File: rtl/result_writeback.sv
// Result writeback: splits 64-bit lane results into low/high register writes behind valid/ready.
// Optional macro WB_SATURATE_EN: clamp each lane to 32-bit signed and issue a single write to dest_lo.
module result_writeback #(
    parameter int LANES  = 16,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*LANES*LANE_W-1:0]    result,
    input  logic [ADDR_W-1:0]            dest_lo,
    input  logic [ADDR_W-1:0]            dest_hi,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [LANES*LANE_W-1:0]      rf_wdata,
    input  logic                         rf_ready,
    output logic                         done,
    output logic [LANES-1:0]             sat_mask
);

    localparam int RES_W  = 2 * LANE_W;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t              state_r;
    logic                rf_we_r;
    logic [ADDR_W-1:0]   rf_waddr_r;
    logic [WORD_W-1:0]   rf_wdata_r;
    logic                done_r;
    logic [WORD_W-1:0]   first_word_s;
    logic                in_ready_s;

    // Gather the low (hi=0) or high (hi=1) 32-bit half of every lane into one register word.
    function automatic logic [WORD_W-1:0] pick_words(input logic [LANES*RES_W-1:0] r,
                                                     input logic hi);
        logic [WORD_W-1:0] w;
        w = {WORD_W{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            if (hi) begin
                w[j*LANE_W +: LANE_W] = r[j*RES_W + LANE_W +: LANE_W];
            end else begin
                w[j*LANE_W +: LANE_W] = r[j*RES_W +: LANE_W];
            end
        end
        return w;
    endfunction

`ifdef WB_SATURATE_EN
    logic [LANES-1:0]    sat_mask_r;
    logic [LANES-1:0]    sat_flags_s;

    // Returns {clamped_flag, value}; a lane fits when its top LANE_W+1 bits are all sign copies.
    function automatic logic [LANE_W:0] clamp_lane(input logic [RES_W-1:0] v);
        if (v[RES_W-1:LANE_W-1] == {(LANE_W+1){v[RES_W-1]}}) begin
            return {1'b0, v[LANE_W-1:0]};
        end else if (v[RES_W-1]) begin
            return {1'b1, 1'b1, {(LANE_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(LANE_W-1){1'b1}}};
        end
    endfunction

    // Clamp every lane of the incoming result and collect the per-lane saturation flags.
    always_comb begin
        logic [LANE_W:0] c;
        first_word_s = {WORD_W{1'b0}};
        sat_flags_s  = {LANES{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            c = clamp_lane(result[j*RES_W +: RES_W]);
            first_word_s[j*LANE_W +: LANE_W] = c[LANE_W-1:0];
            sat_flags_s[j]                   = c[LANE_W];
        end
    end

    // Saturation flags are captured with the operands and persist until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_mask_r <= {LANES{1'b0}};
        end else if (in_valid && state_r == IDLE) begin
            sat_mask_r <= sat_flags_s;
        end else begin
            sat_mask_r <= sat_mask_r;
        end
    end

    assign sat_mask = sat_mask_r;
`else
    logic [WORD_W-1:0]   hi_words_r;
    logic [ADDR_W-1:0]   dest_hi_r;

    // Low words go out first; only the high half needs to be held for the second write.
    always_comb begin
        first_word_s = pick_words(result, 1'b0);
    end

    // Capture the second-write operands on accept so later in_valid traffic cannot disturb them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_words_r <= {WORD_W{1'b0}};
            dest_hi_r  <= {ADDR_W{1'b0}};
        end else if (in_valid && state_r == IDLE) begin
            hi_words_r <= pick_words(result, 1'b1);
            dest_hi_r  <= dest_hi;
        end else begin
            hi_words_r <= hi_words_r;
            dest_hi_r  <= dest_hi_r;
        end
    end

    assign sat_mask = {LANES{1'b0}};
`endif

    // Ready is a pure decode so that a new result can be taken in the same cycle IDLE is reached.
    always_comb begin
        if (state_r == IDLE && !rst) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Sequencer: outputs are loaded one state ahead so each write appears with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_wdata_r <= {WORD_W{1'b0}};
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r    <= WR_LO;
                        rf_we_r    <= 1'b1;
                        rf_waddr_r <= dest_lo;
                        rf_wdata_r <= first_word_s;
                    end else begin
                        rf_we_r    <= 1'b0;
                        rf_wdata_r <= {WORD_W{1'b0}};
                    end
                end
                WR_LO: begin
                    if (rf_ready) begin
`ifdef WB_SATURATE_EN
                        state_r    <= IDLE;
                        rf_we_r    <= 1'b0;
                        rf_wdata_r <= {WORD_W{1'b0}};
                        done_r     <= 1'b1;
`else
                        state_r    <= WR_HI;
                        rf_waddr_r <= dest_hi_r;
                        rf_wdata_r <= hi_words_r;
`endif
                    end else begin
                        state_r <= WR_LO;
                    end
                end
                WR_HI: begin
                    if (rf_ready) begin
                        state_r    <= IDLE;
                        rf_we_r    <= 1'b0;
                        rf_wdata_r <= {WORD_W{1'b0}};
                        done_r     <= 1'b1;
                    end else begin
                        state_r <= WR_HI;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rf_we_r    <= 1'b0;
                    rf_wdata_r <= {WORD_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;
    assign done     = done_r;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: stimulus pushes expected writes, a negedge monitor pops and checks.
module tb_result_writeback;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] result;
    logic [4:0]    dest_lo;
    logic [4:0]    dest_hi;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [511:0]  rf_wdata;
    logic          rf_ready;
    logic          done;
    logic [15:0]   sat_mask;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]   addr;
        logic [511:0] data;
        bit           last;
    } exp_t;

    exp_t sb[$];
    bit          pending_done = 1'b0;
    bit          last_stall   = 1'b0;
    logic [4:0]  last_addr;
    logic [511:0] last_data;

    result_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .dest_lo  (dest_lo),
        .dest_hi  (dest_hi),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_ready (rf_ready),
        .done     (done),
        .sat_mask (sat_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted write, tracks done pulses and stall stability.
    always @(negedge clk) begin
        if (pending_done) begin
            chk("done_pulse", {511'b0, done}, 512'd1);
            pending_done = 1'b0;
        end else if (done) begin
            chk("done_unexpected", {511'b0, done}, 512'd0);
        end
        if (rf_we && last_stall) begin
            chk("stall_addr", {507'b0, rf_waddr}, {507'b0, last_addr});
            chk("stall_data", rf_wdata, last_data);
        end
        if (rf_we && rf_ready && !rst) begin
            if (sb.size() == 0) begin
                chk("write_unexpected", {511'b0, rf_we}, 512'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", {507'b0, rf_waddr}, {507'b0, e.addr});
                chk("write_data", rf_wdata, e.data);
                if (e.last) pending_done = 1'b1;
            end
        end
        last_stall = rf_we && !rf_ready;
        last_addr  = rf_waddr;
        last_data  = rf_wdata;
    end

    // Offer one result and wait (bounded) for it to be accepted; optionally queue its expected writes.
    task automatic send(input logic [1023:0] r, input logic [4:0] lo, input logic [4:0] hi,
                        input logic [511:0] exp_lo, input logic [511:0] exp_hi, input bit push);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        result   = r;
        dest_lo  = lo;
        dest_hi  = hi;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("accept_timeout", {511'b0, ok}, 512'd1);
        if (push) begin
`ifdef WB_SATURATE_EN
            sb.push_back('{addr: lo, data: exp_lo, last: 1'b1});
`else
            sb.push_back('{addr: lo, data: exp_lo, last: 1'b0});
            sb.push_back('{addr: hi, data: exp_hi, last: 1'b1});
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [1023:0] r;
        logic [1023:0] r2;
        logic [511:0]  elo;
        logic [511:0]  ehi;
        logic [511:0]  elo2;
        logic [511:0]  ehi2;

        rst = 1'b1; in_valid = 1'b0; result = '0; dest_lo = 5'd0; dest_hi = 5'd0; rf_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", {511'b0, rf_we}, 512'd0);
        chk("reset_wdata", rf_wdata, 512'd0);
        chk("reset_done", {511'b0, done}, 512'd0);
        chk("reset_satmask", {496'b0, sat_mask}, 512'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {511'b0, in_ready}, 512'd1);

        // Reset during WR_LO: write held by rf_ready=0, then abandoned.
        r = '0; r[63:0] = 64'h0123_4567_89AB_CDEF;
        rf_ready = 1'b0;
        send(r, 5'd9, 5'd10, 512'd0, 512'd0, 1'b0);
        chk("pre_reset_we", {511'b0, rf_we}, 512'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rf_ready = 1'b1;
        #1;
        chk("midreset_we", {511'b0, rf_we}, 512'd0);
        chk("midreset_ready", {511'b0, in_ready}, 512'd1);
        chk("midreset_done", {511'b0, done}, 512'd0);
        repeat (4) @(posedge clk);
        #1;

`ifdef WB_SATURATE_EN
        r = '0; r[63:0] = 64'h0000_0001_0000_0000; r[127:64] = 64'hFFFF_FFFF_FFFF_FFFB;
        elo = '0; elo[31:0] = 32'h7FFF_FFFF; elo[63:32] = 32'hFFFF_FFFB;
        send(r, 5'd2, 5'd6, elo, 512'd0, 1'b1);
        chk("sat_mask", {496'b0, sat_mask}, 512'h0001);
        repeat (4) @(posedge clk);
        #1;
`else
        // Basic with exact latency.
        r = '0; r[63:0] = 64'h0000_0001_8000_0000;
        elo = '0; elo[31:0] = 32'h8000_0000;
        ehi = '0; ehi[31:0] = 32'h0000_0001;
        send(r, 5'd3, 5'd4, elo, ehi, 1'b1);
        chk("basic_lo_we", {511'b0, rf_we}, 512'd1);
        chk("basic_lo_addr", {507'b0, rf_waddr}, 512'd3);
        @(posedge clk);
        #1;
        chk("basic_hi_addr", {507'b0, rf_waddr}, 512'd4);
        chk("basic_hi_data", rf_wdata, ehi);
        @(posedge clk);
        #1;
        chk("basic_done", {511'b0, done}, 512'd1);
        chk("idle_wdata", rf_wdata, 512'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {511'b0, done}, 512'd0);

        // Stall three cycles in WR_HI.
        r = '0; r[255:192] = 64'hDEAD_BEEF_CAFE_F00D;
        elo = '0; elo[127:96] = 32'hCAFE_F00D;
        ehi = '0; ehi[127:96] = 32'hDEAD_BEEF;
        send(r, 5'd12, 5'd13, elo, ehi, 1'b1);
        @(posedge clk);
        #1;
        rf_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold_addr", {507'b0, rf_waddr}, 512'd13);
        chk("stall_no_done", {511'b0, done}, 512'd0);
        rf_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_done", {511'b0, done}, 512'd1);
        repeat (2) @(posedge clk);
        #1;

        // Busy: second result offered while the first is being written.
        r = '0; r[63:0] = 64'h1111_2222_3333_4444; r[1023:960] = 64'hAAAA_BBBB_CCCC_DDDD;
        elo = '0; elo[31:0] = 32'h3333_4444; elo[511:480] = 32'hCCCC_DDDD;
        ehi = '0; ehi[31:0] = 32'h1111_2222; ehi[511:480] = 32'hAAAA_BBBB;
        r2 = '0; r2[383:320] = 64'h0123_4567_89AB_CDEF;
        elo2 = '0; elo2[191:160] = 32'h89AB_CDEF;
        ehi2 = '0; ehi2[191:160] = 32'h0123_4567;
        send(r, 5'd20, 5'd21, elo, ehi, 1'b1);
        in_valid = 1'b1; result = r2; dest_lo = 5'd22; dest_hi = 5'd23;
        @(negedge clk);
        chk("busy_ready_lo", {511'b0, in_ready}, 512'd0);
        @(negedge clk);
        chk("busy_ready_hi", {511'b0, in_ready}, 512'd0);
        send(r2, 5'd22, 5'd23, elo2, ehi2, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // All lanes -1, and dest_lo == dest_hi.
        r = {1024{1'b1}};
        send(r, 5'd31, 5'd31, {512{1'b1}}, {512{1'b1}}, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        r = '0; r[127:64] = 64'h5555_6666_7777_8888;
        elo = '0; elo[63:32] = 32'h7777_8888;
        ehi = '0; ehi[63:32] = 32'h5555_6666;
        send(r, 5'd7, 5'd7, elo, ehi, 1'b1);
        repeat (4) @(posedge clk);
        #1;
`endif

        chk("scoreboard_empty", 512'(sb.size()), 512'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
